// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the BNN classifier core.
// Weight map: hidden rows, then hidden biases, then class rows.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIDDEN = 2'd1,
    OUTPUT = 2'd2,
    DONE   = 2'd3
  } bnn_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int HID_BASE = 0;

  function automatic int bias_base(input int n_hid);
    return n_hid;
  endfunction

  function automatic int cls_base(input int n_hid);
    return 2 * n_hid;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR of two W-bit vectors followed by a popcount of the
// agreeing bit positions.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int W = 4,
  localparam int CW = clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [CW-1:0] cnt
);

  logic [W-1:0] agree;

  for (genvar gi = 0; gi < W; gi++) begin : g_xnor
    assign agree[gi] = ~(a[gi] ^ b[gi]);
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(agree[i]);
    end
  end

endmodule

// File: rtl/bnn_classifier_core.sv
// Sequential binarised-NN classifier: one hidden neuron per cycle, then one
// class score per cycle with lowest-index tie-break. Optional BNN_SCORE_OUT_EN adds out_score.
module bnn_classifier_core
  import bnn_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int FEAT_W = 4,
  parameter int N_HID  = 4,
  parameter int N_CLS  = 2,
  parameter int BIAS_W = 4,
  localparam int AW  = clog2(2 * N_HID + N_CLS),
  localparam int DW  = max2(N_IN, max2(N_HID, BIAS_W)),
  localparam int OCW = max2(1, clog2(N_CLS)),
  localparam int SW  = clog2(N_HID + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*FEAT_W-1:0] in_feat,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OCW-1:0]         out_class,
`ifdef BNN_SCORE_OUT_EN
  output logic [SW-1:0]          out_score,
`endif
  output logic [N_HID-1:0]       out_hidden
);

  localparam int PCW = clog2(N_IN + 1);
  localparam int PW  = max2(BIAS_W, PCW + 1) + 1;
  localparam int CW  = max2(1, clog2(max2(N_HID, N_CLS)));

  bnn_state_e state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [N_HID-1:0]  act_q, act_d;
  logic [SW-1:0]     best_score_q, best_score_d;
  logic [OCW-1:0]    best_idx_q, best_idx_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [OCW-1:0]    out_class_q, out_class_d;
  logic [N_HID-1:0]  out_hidden_q, out_hidden_d;
`ifdef BNN_SCORE_OUT_EN
  logic [SW-1:0]     score_q, score_d;
`endif

  logic [N_IN-1:0]   hid_w_q [N_HID];
  logic [N_IN-1:0]   hid_w_d [N_HID];
  logic [BIAS_W-1:0] bias_q  [N_HID];
  logic [BIAS_W-1:0] bias_d  [N_HID];
  logic [N_HID-1:0]  cls_w_q [N_CLS];
  logic [N_HID-1:0]  cls_w_d [N_CLS];

  logic [N_IN-1:0]   feat_bits;
  logic [N_IN-1:0]   hid_row;
  logic [BIAS_W-1:0] bias_sel;
  logic [N_HID-1:0]  cls_row;
  logic [PCW-1:0]    hid_pc;
  logic [SW-1:0]     cls_score;
  logic signed [PW-1:0] pre_act;
  logic              neuron_act;
  logic              wr_ok;
  logic [SW-1:0]     best_score_n;
  logic [OCW-1:0]    best_idx_n;

  // A feature binarises to 1 when it sits in the upper half of its range.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_bin
    assign feat_bits[gi] = (in_feat[gi*FEAT_W +: FEAT_W] >= FEAT_W'(1 << (FEAT_W - 1)));
  end

  always_comb begin
    hid_row  = '0;
    bias_sel = '0;
    cls_row  = '0;
    for (int h = 0; h < N_HID; h++) begin
      if (cnt_q == CW'(h)) begin
        hid_row  = hid_w_q[h];
        bias_sel = bias_q[h];
      end
    end
    for (int c = 0; c < N_CLS; c++) begin
      if (cnt_q == CW'(c)) begin
        cls_row = cls_w_q[c];
      end
    end
  end

  bnn_xnor_popcount #(.W(N_IN)) u_hid_pc (
    .a   (x_q),
    .b   (hid_row),
    .cnt (hid_pc)
  );

  bnn_xnor_popcount #(.W(N_HID)) u_cls_pc (
    .a   (act_q),
    .b   (cls_row),
    .cnt (cls_score)
  );

  assign pre_act = $signed({{(PW - PCW){1'b0}}, hid_pc})
                 + $signed({{(PW - BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel});
  assign neuron_act = ~pre_act[PW-1];

  // Weight updates are only honoured while idle; unmatched addresses fall through.
  always_comb begin
    wr_ok   = wr_en && (state_q == IDLE);
    hid_w_d = hid_w_q;
    bias_d  = bias_q;
    cls_w_d = cls_w_q;
    for (int h = 0; h < N_HID; h++) begin
      if (wr_ok && wr_addr == AW'(HID_BASE + h)) hid_w_d[h] = wr_data[N_IN-1:0];
      if (wr_ok && wr_addr == AW'(bias_base(N_HID) + h)) bias_d[h] = wr_data[BIAS_W-1:0];
    end
    for (int c = 0; c < N_CLS; c++) begin
      if (wr_ok && wr_addr == AW'(cls_base(N_HID) + c)) cls_w_d[c] = wr_data[N_HID-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    act_d        = act_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    out_class_d  = out_class_q;
    out_hidden_d = out_hidden_q;
`ifdef BNN_SCORE_OUT_EN
    score_d      = score_q;
`endif
    best_score_n = best_score_q;
    best_idx_n   = best_idx_q;
    if ((cnt_q == '0) || (cls_score > best_score_q)) begin
      best_score_n = cls_score;
      best_idx_n   = OCW'(cnt_q);
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = feat_bits;
          cnt_d   = '0;
          state_d = HIDDEN;
        end
      end
      HIDDEN: begin
        for (int h = 0; h < N_HID; h++) begin
          if (cnt_q == CW'(h)) act_d[h] = neuron_act;
        end
        if (cnt_q == CW'(N_HID - 1)) begin
          cnt_d   = '0;
          state_d = OUTPUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUTPUT: begin
        best_score_d = best_score_n;
        best_idx_d   = best_idx_n;
        if (cnt_q == CW'(N_CLS - 1)) begin
          state_d      = DONE;
          out_class_d  = best_idx_n;
          out_hidden_d = act_q;
`ifdef BNN_SCORE_OUT_EN
          score_d      = best_score_n;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      act_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_hidden_q <= '0;
`ifdef BNN_SCORE_OUT_EN
      score_q      <= '0;
`endif
      hid_w_q      <= '{default: '0};
      bias_q       <= '{default: '0};
      cls_w_q      <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      act_q        <= act_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_hidden_q <= out_hidden_d;
`ifdef BNN_SCORE_OUT_EN
      score_q      <= score_d;
`endif
      hid_w_q      <= hid_w_d;
      bias_q       <= bias_d;
      cls_w_q      <= cls_w_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_hidden = out_hidden_q;
`ifdef BNN_SCORE_OUT_EN
  assign out_score  = score_q;
`endif

endmodule

// File: tb/tb_bnn_classifier_core.sv
// Directed bench for bnn_classifier_core (default parameters) with a weight
// model and an expected-result queue; out_score checks apply under BNN_SCORE_OUT_EN.
module tb_bnn_classifier_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_feat;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_class;
  logic [3:0]  out_hidden;
`ifdef BNN_SCORE_OUT_EN
  logic [2:0]  out_score;
`endif

  always #5 clk = ~clk;

  bnn_classifier_core dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_feat    (in_feat),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
`ifdef BNN_SCORE_OUT_EN
    .out_score  (out_score),
`endif
    .out_hidden (out_hidden)
  );

  typedef struct packed {
    logic [0:0] cls;
    logic [3:0] hid;
    logic [2:0] score;
  } exp_t;

  exp_t sb[$];
  logic [3:0]        m_hid  [4];
  logic signed [3:0] m_bias [4];
  logic [3:0]        m_cls  [2];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_hid[i]  = 4'h0;
      m_bias[i] = 4'sh0;
    end
    m_cls[0] = 4'h0;
    m_cls[1] = 4'h0;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [3:0] d);
    int ai;
    ai = int'(a);
    if (ai < 4)       m_hid[ai]     = d;
    else if (ai < 8)  m_bias[ai-4]  = d;
    else if (ai < 10) m_cls[ai-8]   = d;
  endfunction

  function automatic exp_t model(input logic [15:0] feat);
    exp_t r;
    logic [3:0] x;
    logic [3:0] act;
    int pc, pre, s, best;
    for (int k = 0; k < 4; k++) x[k] = (feat[k*4 +: 4] >= 4'd8);
    for (int h = 0; h < 4; h++) begin
      pc = 0;
      for (int k = 0; k < 4; k++) if (x[k] == m_hid[h][k]) pc++;
      pre = pc + int'(m_bias[h]);
      act[h] = (pre >= 0);
    end
    best = -1;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      s = 0;
      for (int h = 0; h < 4; h++) if (act[h] == m_cls[c][h]) s++;
      if (s > best) begin
        best  = s;
        r.cls = 1'(c);
      end
    end
    r.hid   = act;
    r.score = 3'(best);
    return r;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  // Launch one inference (optionally with a same-cycle weight write) and check its result.
  task automatic start_and_wait(input string tag, input logic [15:0] feat,
                                input bit same_wr, input logic [3:0] a, input logic [3:0] d,
                                output exp_t got);
    int lat;
    exp_t e;
    @(negedge clk);
    chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_feat = feat; in_valid = 1'b1;
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      model_write(a, d);
    end
    sb.push_back(model(feat));
    @(negedge clk);
    in_valid = 1'b0; wr_en = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 30) begin
      chk({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd7);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, " out_class"}, 32'(out_class), 32'(e.cls));
    chk({tag, " out_hidden"}, 32'(out_hidden), 32'(e.hid));
`ifdef BNN_SCORE_OUT_EN
    chk({tag, " out_score"}, 32'(out_score), 32'(e.score));
`endif
    $display("[TB] %s feat=%h class=%0d hidden=%b latency=%0d", tag, feat, out_class, out_hidden, lat);
    got = e;
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  exp_t r1, r2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_feat = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_class", 32'(out_class), 32'd0);
    chk("reset out_hidden", 32'(out_hidden), 32'd0);

    // All-zero weights: every neuron fires, classes tie at 0.
    start_and_wait("t1", 16'h3333, 1'b0, 4'h0, 4'h0, r1);
    chk("t1 class_const", 32'(out_class), 32'd0);
    chk("t1 hidden_const", 32'(out_hidden), 32'hF);
    finish_out("t1");

    wr(4'd9, 4'b1111);
    start_and_wait("t2", 16'h3333, 1'b0, 4'h0, 4'h0, r1);
    chk("t2 class_const", 32'(out_class), 32'd1);
    finish_out("t2");

    for (int i = 4; i < 8; i++) wr(4'(i), 4'b1011);
    start_and_wait("t3", 16'h3333, 1'b0, 4'h0, 4'h0, r1);
    chk("t3 class_const", 32'(out_class), 32'd0);
    chk("t3 hidden_const", 32'(out_hidden), 32'd0);
    finish_out("t3");

    // Back-pressure: outputs must hold, and writes while busy are dropped.
    out_ready = 1'b0;
    start_and_wait("t4", 16'h3333, 1'b0, 4'h0, 4'h0, r1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin wr_en = 1'b1; wr_addr = 4'd8; wr_data = 4'hF; end
      else if (i == 4) begin wr_en = 1'b1; wr_addr = 4'd4; wr_data = 4'h7; end
      else wr_en = 1'b0;
      @(negedge clk);
      chk("t4 hold out_valid", 32'(out_valid), 32'd1);
      chk("t4 hold out_class", 32'(out_class), 32'(r1.cls));
      chk("t4 hold out_hidden", 32'(out_hidden), 32'(r1.hid));
      chk("t4 hold in_ready", 32'(in_ready), 32'd0);
    end
    wr_en = 1'b0;
    finish_out("t4");
    start_and_wait("t4 rerun", 16'h3333, 1'b0, 4'h0, 4'h0, r2);
    chk("t4 rerun class", 32'(r2.cls), 32'(r1.cls));
    chk("t4 rerun hidden_dut", 32'(out_hidden), 32'(r1.hid));
    finish_out("t4 rerun");

    // Write landing on the accept edge is seen by that inference (bias0 = +7).
    start_and_wait("t5 same-cycle wr", 16'h3333, 1'b1, 4'd4, 4'd7, r1);
    chk("t5 hidden_const", 32'(out_hidden), 32'b0001);
    finish_out("t5");

    // Reset in the second HIDDEN cycle aborts the run and clears weights.
    @(negedge clk);
    in_feat = 16'hF0F0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("t6 rst in_ready", 32'(in_ready), 32'd1);
    chk("t6 rst out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 3 == 0) chk("t6 no result", 32'(out_valid), 32'd0);
    end
    start_and_wait("t6 rerun", 16'h3333, 1'b0, 4'h0, 4'h0, r1);
    chk("t6 class_const", 32'(out_class), 32'd0);
    chk("t6 hidden_const", 32'(out_hidden), 32'hF);
    finish_out("t6");

    wr(4'd12, 4'hF);
    for (int round = 0; round < 3; round++) begin
      for (int a = 0; a < 10; a++) wr(4'(a), 4'($urandom_range(0, 15)));
      for (int n = 0; n < 3; n++) begin
        start_and_wait("rand", 16'($urandom), 1'b0, 4'h0, 4'h0, r1);
        finish_out("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bnn_classifier_core.md
# bnn_classifier_core

Parametrised, sequential binarised-neural-network classifier for the microgreen sorting datapath. It replaces the fixed 4-input / 4-hidden / 2-class inference block with configurable feature count, hidden width and class count. Weights are runtime-writable instead of hard-coded. Each hidden neuron is evaluated one per cycle, then each class one per cycle. Features enter and results leave through valid/ready handshakes, so the block sits between the sensor-feature front end and the sorter actuator logic.

## Interface
- N_IN, 4: number of input features.
- FEAT_W, 4: bits per feature.
- N_HID, 4: hidden neurons.
- N_CLS, 2: output classes (>=2).
- BIAS_W, 4: signed hidden-bias width.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  block idle and accepting.
- in_feat  in  N_IN*FEAT_W  features; feature k at [k*FEAT_W +: FEAT_W].
- wr_en  in  1  weight write strobe.
- wr_addr  in  clog2(2*N_HID+N_CLS)  weight address.
- wr_data  in  max(N_IN,N_HID,BIAS_W)  write data, LSB-aligned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_class  out  max(1,clog2(N_CLS))  winning class index.
- out_hidden  out  N_HID  hidden activation vector.

## Operation
- Weight map:
  - addr 0..N_HID-1: hidden row h, N_IN bits.
  - N_HID..2*N_HID-1: bias h, signed BIAS_W.
  - 2*N_HID..2*N_HID+N_CLS-1: class row c, N_HID bits.
- A write is performed only when wr_en=1 and the state is IDLE. Writes in any other state, or to an out-of-range address, are ignored.
- Binarize on accept: bit k = 1 when feature k >= 2^(FEAT_W-1). Latch the bit vector.
- Hidden neuron h:
  - popcount = popcount(~(x ^ Wh)), width clog2(N_IN+1).
  - pre-activation = popcount + sign-extended bias, evaluated in a signed width of max(BIAS_W, clog2(N_IN+1)+1)+1 bits.
  - act[h] = (pre-activation >= 0).
- Class score c = popcount(~(act ^ Vc)), width clog2(N_HID+1).
- Argmax runs over classes, evaluated in ascending index order. A later class replaces the best only if its score is strictly greater, so ties resolve to the lowest index.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch the bits, set the counter to 0, go to HIDDEN.
  - HIDDEN: compute neuron h = counter per cycle. After N_HID-1, clear the counter and go to OUTPUT.
  - OUTPUT: score class c = counter per cycle and update the best. After N_CLS-1, go to DONE.
  - DONE: out_valid=1. Outputs are held stable until out_ready=1, then go to IDLE.
- out_class and out_hidden hold their last values outside DONE. They are only meaningful while out_valid=1.
- Reset:
  - state = IDLE, in_ready=1, out_valid=0, out_class=0, out_hidden=0.
  - All weights and biases are cleared to 0.
  - Reset mid-inference aborts the inference; no result is produced.

## Timing
- Accept at edge T0 (in_valid & in_ready).
- out_valid rises after edge T0+N_HID+N_CLS: N_HID+N_CLS+1 cycles of latency. With defaults, out_valid is seen in cycle 7.
- in_ready is low from the cycle after accept until the cycle after the out handshake. There is no overlap of inferences.
- The out handshake and the next in handshake cannot coincide. Minimum initiation interval is N_HID+N_CLS+2 cycles.
- A wr_en in the same cycle as an accepting in_valid is applied, because the state is still IDLE. The new inference uses the updated weight only from the next cycle, so hidden row writes are visible to that inference.

## Configuration
- BNN_SCORE_OUT_EN defined:
  - Adds output out_score, width clog2(N_HID+1), giving the winning class score.
  - Valid with out_valid; reset value 0.
- BNN_SCORE_OUT_EN undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- The shared package bnn_pkg holds:
  - the state enum (IDLE, HIDDEN, OUTPUT, DONE);
  - a clog2 helper;
  - the weight-map base offset constants (HID_BASE=0, BIAS_BASE, CLS_BASE), as functions of N_HID.
- One sub-module, bnn_xnor_popcount: a parametrised width W, combinational XNOR and popcount. It is instanced twice: once at width N_IN and once at width N_HID.
- Weight storage, FSM and argmax live in the top module.

## Test plan
- Reset, no writes, feat=all 0x3:
  - x=0000 and all weights 0 give popcount 4 and act 1111.
  - Both class scores are 0, so the tie gives out_class=0, out_hidden=4'b1111 at cycle 7.
- Write class row 1 = 4'b1111 (addr 9), same stimulus -> score1=4 > score0=0, out_class=1.
- Write all biases to -5 (addrs 4..7) -> pre-activation is -1, act 0000, score0=4, score1=0, out_class=0, out_hidden=0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_class and out_hidden stable, in_ready=0. A write to addr 8 during this time is ignored: a re-run gives the same result.
- Assert rst in HIDDEN cycle 2 -> next cycle in_ready=1, out_valid=0. All weights read back as zero behaviour (repeat test 1 result).
- With BNN_SCORE_OUT_EN, run test 2 -> out_score=4. Without the macro, the build has no out_score port.
